data_bus_arbiter: RTL

- Two-port arbiter that shares the single CPU data bus (RAM plus memory-mapped IO window) between requester 0 (CPU load/store unit) and requester 1 (DMA/debug loader).
- Each requester uses a req/ack handshake. The arbiter selects one request, drives the shared bus for exactly one access cycle, captures read data and returns it with a one-cycle ack.
- The block sits between the requesters and the data bus, and it is the only driver of the bus address and write-enable.

---
 rtl/data_bus_arbiter_pkg.sv | 14 +
 rtl/data_bus_arbiter_if.sv | 50 +++++
 rtl/data_bus_arbiter_rr_arbiter2.sv | 25 ++
 rtl/data_bus_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/data_bus_arbiter_pkg.sv
// Shared types and constants for the CPU data-bus arbiter.
// Port indices are one bit wide so they can be stored directly in the grant and last registers.
package data_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Requester handshakes plus the shared data bus, grouped for the arbiter.
// The master side holds the requesters and the bus memory; the slave side is the arbiter.
interface data_bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic              req0;
   logic [ADDR_W-1:0] addr0;
   logic              we0;
   logic [DATA_W-1:0] wdata0;
   logic              ack0;
   logic [DATA_W-1:0] rdata0;

   logic              req1;
   logic [ADDR_W-1:0] addr1;
   logic              we1;
   logic [DATA_W-1:0] wdata1;
   logic              ack1;
   logic [DATA_W-1:0] rdata1;

   logic [ADDR_W-1:0] bus_addr;
   logic              bus_we;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata;

   logic              busy;
   logic              grant;

   modport master (
      output req0, addr0, we0, wdata0,
      input  ack0, rdata0,
      output req1, addr1, we1, wdata1,
      input  ack1, rdata1,
      input  bus_addr, bus_we, bus_wdata,
      output bus_rdata,
      input  busy, grant
   );

   modport slave (
      input  req0, addr0, we0, wdata0,
      output ack0, rdata0,
      input  req1, addr1, we1, wdata1,
      output ack1, rdata1,
      output bus_addr, bus_we, bus_wdata,
      input  bus_rdata,
      output busy, grant
   );

endinterface

// File: rtl/data_bus_arbiter_rr_arbiter2.sv
// Two-input combinational winner select.
// Round-robin mode favours the port that did not win last time; fixed mode always favours port 0.
module rr_arbiter2
   import data_bus_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_i,
   output logic valid_o,
   output logic winner_o
);

   always_comb begin
      valid_o  = req0_i | req1_i;
      winner_o = PORT_CPU;
      if (req0_i && req1_i) begin
         winner_o = RR_EN ? ~last_i : PORT_CPU;
      end else if (req1_i) begin
         winner_o = PORT_DMA;
      end
   end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares the CPU data bus between the load/store unit (port 0) and the DMA/debug loader (port 1).
// Each transaction is IDLE -> ACCESS -> DONE: one bus cycle, then a one-cycle ack to the winner.
module data_bus_arbiter
   import data_bus_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter bit RR_EN  = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   data_bus_arbiter_if.slave bus_if
);

   arb_state_t        state_q, state_d;
   logic              last_q, last_d;
   logic              grant_q, grant_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;

   logic              win_valid;
   logic              win_port;

   rr_arbiter2 #(
      .RR_EN(RR_EN)
   ) u_rr_arbiter2 (
      .req0_i   (bus_if.req0),
      .req1_i   (bus_if.req1),
      .last_i   (last_q),
      .valid_o  (win_valid),
      .winner_o (win_port)
   );

   // last resets to port 1 so that port 0 wins the first tie after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         last_q   <= PORT_DMA;
         grant_q  <= PORT_CPU;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         grant_q  <= grant_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      grant_d  = grant_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;

      case (state_q)
         IDLE: begin
            if (win_valid) begin
               addr_d  = (win_port == PORT_DMA) ? bus_if.addr1  : bus_if.addr0;
               we_d    = (win_port == PORT_DMA) ? bus_if.we1    : bus_if.we0;
               wdata_d = (win_port == PORT_DMA) ? bus_if.wdata1 : bus_if.wdata0;
               grant_d = win_port;
               last_d  = win_port;
               state_d = ACCESS;
            end
         end

         // Write enable is cleared on the way out so it is high for the ACCESS cycle only.
         ACCESS: begin
            if (!we_q) begin
               if (grant_q == PORT_DMA) begin
                  rdata1_d = bus_if.bus_rdata;
               end else begin
                  rdata0_d = bus_if.bus_rdata;
               end
            end
            we_d    = 1'b0;
            state_d = DONE;
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus_if.bus_addr  = addr_q;
   assign bus_if.bus_we    = we_q;
   assign bus_if.bus_wdata = wdata_q;
   assign bus_if.rdata0    = rdata0_q;
   assign bus_if.rdata1    = rdata1_q;
   assign bus_if.grant     = grant_q;
   assign bus_if.busy      = (state_q != IDLE);
   assign bus_if.ack0      = (state_q == DONE) && (grant_q == PORT_CPU);
   assign bus_if.ack1      = (state_q == DONE) && (grant_q == PORT_DMA);

endmodule
